// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-stage constants, also consumed by the decode/execute stages.
package instruction_fetch_pkg;

  localparam int          INSTR_W   = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int          PC_STEP   = 4;

  // Issue is allowed while fewer than two words are owned, or at two when one leaves now.
  function automatic logic can_issue(input logic [1:0] occ, input logic pop);
    return (occ < 2'd2) || ((occ == 2'd2) && pop);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of {pc, instr} with push/pop/flush, full/empty and an occupancy count.
module fetch_queue #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  logic [W-1:0] r_mem [2];
  logic         r_wptr;
  logic         r_rptr;
  logic [1:0]   r_cnt;
  logic         w_do_pop;
  logic         w_do_push;

  assign w_do_pop  = pop && (r_cnt != 2'd0);
  assign w_do_push = push && ((r_cnt != 2'd2) || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_cnt  <= 2'd0;
    end else if (flush) begin
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_cnt  <= 2'd0;
    end else begin
      if (w_do_push) r_wptr <= ~r_wptr;
      if (w_do_pop)  r_rptr <= ~r_rptr;
      r_cnt <= r_cnt + {1'b0, w_do_push} - {1'b0, w_do_pop};
    end
  end

  // Payload storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (w_do_push && !flush) r_mem[r_wptr] <= push_data;
  end

  assign head  = r_mem[r_rptr];
  assign full  = (r_cnt == 2'd2);
  assign empty = (r_cnt == 2'd0);
  assign count = r_cnt;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, epoch and issue control feeding a 2-entry return queue.
// Optional macro IFETCH_MISALIGN_CHECK_EN adds a sticky fetch_fault that halts fetch on misaligned redirects.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready
`ifdef IFETCH_MISALIGN_CHECK_EN
  ,output logic              fetch_fault
`endif
);

  localparam int QW = ADDR_W + INSTR_W;

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_ifl_pc;
  logic              r_inflight;
  logic              r_epoch;
  logic              r_iss_epoch;
  logic              w_halt;
  logic              w_pop;
  logic              w_push;
  logic [1:0]        w_cnt;
  logic [1:0]        w_q_count;
  logic              w_q_full;
  logic              w_q_empty;
  logic [QW-1:0]     w_q_head;
  logic [ADDR_W-1:0] w_redir_pc;

  assign w_redir_pc = redirect_pc & ~ADDR_W'(3);
  assign w_pop      = instr_valid && instr_ready;
  assign w_cnt      = w_q_count + {1'b0, r_inflight};

  assign imem_req  = rst_n && !redirect_valid && !w_halt && can_issue(w_cnt, w_pop);
  assign imem_addr = r_pc;

  // A returning word is kept only if no redirect has happened since it was issued.
  assign w_push = r_inflight && (r_iss_epoch == r_epoch) && !redirect_valid &&
                  (!w_q_full || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= RESET_PC;
      r_inflight  <= 1'b0;
      r_epoch     <= 1'b0;
      r_iss_epoch <= 1'b0;
    end else if (redirect_valid) begin
      r_pc       <= w_redir_pc;
      r_inflight <= 1'b0;
      r_epoch    <= ~r_epoch;
    end else begin
      r_inflight <= imem_req;
      if (imem_req) begin
        r_pc        <= r_pc + ADDR_W'(PC_STEP);
        r_iss_epoch <= r_epoch;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (imem_req) r_ifl_pc <= r_pc;
  end

`ifdef IFETCH_MISALIGN_CHECK_EN
  logic r_fault;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              r_fault <= 1'b0;
    else if (redirect_valid) r_fault <= |redirect_pc[1:0];
  end

  assign w_halt      = r_fault;
  assign fetch_fault = r_fault;
`else
  assign w_halt = 1'b0;
`endif

  fetch_queue #(.W(QW)) u_queue (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (w_push),
    .pop      (w_pop),
    .flush    (redirect_valid || w_halt),
    .push_data({r_ifl_pc, imem_rdata}),
    .head     (w_q_head),
    .full     (w_q_full),
    .empty    (w_q_empty),
    .count    (w_q_count)
  );

  assign instr_valid = !w_q_empty;
  assign instr       = instr_valid ? w_q_head[INSTR_W-1:0] : NOP_INSTR;
  assign instr_pc    = instr_valid ? w_q_head[QW-1:INSTR_W] : '0;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: ROM model mem[a]=a*16+1, expected-stream scoreboard, directed and random phases.
`define assertCaseEqual(act, exp, name) chk(name, 32'(act), 32'(exp))

module tb_instruction_fetch;

  localparam logic [31:0] RST_PC = 32'h0;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'hDEAD_BEEF;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
`ifdef IFETCH_MISALIGN_CHECK_EN
  logic        fetch_fault;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  instruction_fetch #(.ADDR_W(32), .RESET_PC(RST_PC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_ready   (instr_ready)
`ifdef IFETCH_MISALIGN_CHECK_EN
    ,.fetch_fault  (fetch_fault)
`endif
  );

  // Instruction ROM with fixed one-cycle read latency.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= imem_addr * 32'd16 + 32'd1;
    else          imem_rdata <= 32'hDEAD_BEEF;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: after reset or redirect the presented stream is target, target+4, ...
  logic [31:0] expq[$];
  logic [31:0] gen_pc;
  bit          mdl_halted;

  function automatic void restart(input logic [31:0] pc);
    expq.delete();
    gen_pc = pc;
  endfunction

  initial begin
    restart(RST_PC);
    mdl_halted = 1'b0;
  end

  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst_n) begin
      restart(RST_PC);
      mdl_halted = 1'b0;
      `assertCaseEqual(instr_valid, 1'b0, "rst_valid");
    end else begin
      `assertCaseEqual(dut.u_queue.count <= 2'd2, 1'b1, "q_overflow");
      if (imem_req) `assertCaseEqual(imem_addr[1:0], 2'b00, "addr_align");
      if (!instr_valid) `assertCaseEqual(instr, NOP, "nop_idle");
      if (instr_valid && instr_ready) begin
        if (mdl_halted) begin
          `assertCaseEqual(instr_valid, 1'b0, "pop_while_halted");
        end else begin
          while (expq.size() < 4) begin
            expq.push_back(gen_pc);
            gen_pc = gen_pc + 32'd4;
          end
          e = expq.pop_front();
          n_vec++;
          if (instr_pc !== e) begin
            n_err++;
            $display("FAIL sb_pc: got %h, expected %h at %0t", instr_pc, e, $time);
          end
          n_vec++;
          if (instr !== (e * 32'd16 + 32'd1)) begin
            n_err++;
            $display("FAIL sb_instr: got %h, expected %h at %0t", instr, e * 32'd16 + 32'd1, $time);
          end
        end
      end
      if (redirect_valid) begin
`ifdef IFETCH_MISALIGN_CHECK_EN
        mdl_halted = (redirect_pc[1:0] != 2'b00);
`endif
        restart(redirect_pc & ~32'd3);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    rst_n = 1'b0;
    instr_ready = rdy;
    redirect_valid = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc = pc;
    step();
    redirect_valid = 1'b0;
    #1;
  endtask

  initial begin
    int r;
    rst_n = 1'b0;
    instr_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    repeat (2) step();
    `assertCaseEqual(instr_valid, 1'b0, "reset_valid");
    `assertCaseEqual(instr, NOP, "reset_instr");
    `assertCaseEqual(instr_pc, 32'h0, "reset_pc");
    `assertCaseEqual(imem_req, 1'b0, "reset_req");
`ifdef IFETCH_MISALIGN_CHECK_EN
    `assertCaseEqual(fetch_fault, 1'b0, "reset_fault");
`endif

    // Reset release: back-to-back issue and two-cycle latency.
    rst_n = 1'b1;
    #1;
    `assertCaseEqual(imem_req, 1'b1, "t1_req0");
    `assertCaseEqual(imem_addr, 32'h0, "t1_addr0");
    step(); `assertCaseEqual(imem_addr, 32'h4, "t1_addr4");
    `assertCaseEqual(instr_valid, 1'b0, "t1_lat1");
    step(); `assertCaseEqual(imem_addr, 32'h8, "t1_addr8");
    `assertCaseEqual(instr_valid, 1'b1, "t1_valid");
    `assertCaseEqual(instr_pc, 32'h0, "t1_pc0");
    step(); `assertCaseEqual(instr_pc, 32'h4, "t1_pc4");
    step(); `assertCaseEqual(instr_pc, 32'h8, "t1_pc8");

    // Backpressure: at most two words owned, head frozen.
    do_reset(1'b0);
    repeat (5) step();
    `assertCaseEqual(imem_req, 1'b0, "t2_req_stop");
    `assertCaseEqual(instr_pc, 32'h0, "t2_frozen_pc");
    `assertCaseEqual(instr, 32'h1, "t2_frozen_instr");
    instr_ready = 1'b1;
    step(); `assertCaseEqual(instr_pc, 32'h4, "t2_pc4");
    step(); `assertCaseEqual(instr_pc, 32'h8, "t2_pc8");
    instr_ready = 1'b0;
    repeat (3) step();
    `assertCaseEqual(dut.u_queue.count, 2'd2, "t3_two_queued");

    // Redirect with two queued words.
    redirect(32'h100);
    `assertCaseEqual(instr_valid, 1'b0, "t3_flushed");
    `assertCaseEqual(imem_req, 1'b1, "t3_req");
    `assertCaseEqual(imem_addr, 32'h100, "t3_addr");
    instr_ready = 1'b1;
    step(); step();
    `assertCaseEqual(instr_valid, 1'b1, "t3_valid");
    `assertCaseEqual(instr_pc, 32'h100, "t3_pc");

    // Redirect right after an issue: in-flight word dropped.
    repeat (4) step();
    `assertCaseEqual(imem_req, 1'b1, "t4_issue");
    step();
    redirect(32'h300);
    `assertCaseEqual(instr_valid, 1'b0, "t4_flushed");
    step(); step();
    `assertCaseEqual(instr_pc, 32'h300, "t4_pc");

    // Asynchronous reset mid-stream.
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    `assertCaseEqual(instr_valid, 1'b0, "t5_valid");
    `assertCaseEqual(instr, NOP, "t5_instr");
    `assertCaseEqual(instr_pc, 32'h0, "t5_pc");
    `assertCaseEqual(imem_req, 1'b0, "t5_req");
    step();
    rst_n = 1'b1;
    #1;
    `assertCaseEqual(imem_addr, RST_PC, "t5_restart");
    step(); step();
    `assertCaseEqual(instr_pc, RST_PC, "t5_first_pc");

    // Misaligned redirect.
    repeat (3) step();
    redirect(32'h102);
`ifdef IFETCH_MISALIGN_CHECK_EN
    `assertCaseEqual(fetch_fault, 1'b1, "t6_fault");
    `assertCaseEqual(imem_req, 1'b0, "t6_halt_req");
    repeat (3) step();
    `assertCaseEqual(imem_req, 1'b0, "t6_still_halted");
    `assertCaseEqual(instr_valid, 1'b0, "t6_empty");
    redirect(32'h200);
    `assertCaseEqual(fetch_fault, 1'b0, "t6_fault_clr");
    `assertCaseEqual(imem_req, 1'b1, "t6_resume_req");
    `assertCaseEqual(imem_addr, 32'h200, "t6_resume_addr");
`else
    `assertCaseEqual(imem_req, 1'b1, "t6_req");
    `assertCaseEqual(imem_addr, 32'h100, "t6_forced_align");
`endif

    // Randomized traffic checked by the scoreboard.
    repeat (2000) begin
      step();
      redirect_valid = 1'b0;
      rst_n = 1'b1;
      r = int'($urandom_range(0, 255));
      instr_ready = ($urandom_range(0, 3) != 0);
      if (r < 2) begin
        rst_n = 1'b0;
      end else if (r < 16) begin
        redirect_valid = 1'b1;
        redirect_pc = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
        if (r < 4) redirect_pc[1:0] = 2'($urandom_range(1, 3));
      end
    end
    step();
    redirect_valid = 1'b0;
    rst_n = 1'b1;
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
